bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master shared-bus arbiter with fair tie-breaking and
// a bounded hold time under contention.
//
// Parameters:
//   MAX_HOLD   - max consecutive cycles one master keeps the bus while the
//                other master is requesting
// Ports:
//   clk, reset                        - rising-edge clock, sync active-high reset
//   m0_req/m0_wr/m0_address/m0_dout   - master 0 (CPU) request and transfer
//   m1_req/m1_wr/m1_address/m1_dout   - master 1 (DMAC) request and transfer
//   m0_grant, m1_grant                - bus ownership, never both high
//   s_wr, s_address, s_din            - shared bus to the slaves
//   bus_err                           - owner addresses outside the slave map
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [15:0] m0_address,
  input  logic [31:0] m0_dout,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [15:0] m1_address,
  input  logic [31:0] m1_dout,
  output logic        m0_grant,
  output logic        m1_grant,
  output logic        s_wr,
  output logic [15:0] s_address,
  output logic [31:0] s_din,
  output logic        bus_err
);

  localparam int unsigned CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t        state;
  logic          last_owner;
  logic [CW-1:0] hold_cnt;
  logic          own_req;
  logic          wr_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (m0_req && m1_req) begin
            // tie goes to whoever did not own the bus last
            if (last_owner) begin
              state      <= GRANT0;
              last_owner <= 1'b0;
            end else begin
              state      <= GRANT1;
              last_owner <= 1'b1;
            end
          end else if (m0_req) begin
            state      <= GRANT0;
            last_owner <= 1'b0;
          end else if (m1_req) begin
            state      <= GRANT1;
            last_owner <= 1'b1;
          end
        end
        GRANT0: begin
          if (!m0_req) begin
            // release always wins over preemption
            hold_cnt <= '0;
            if (m1_req) begin
              state      <= GRANT1;
              last_owner <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (m1_req) begin
            if (hold_cnt == HOLD_LAST) begin
              state      <= GRANT1;
              last_owner <= 1'b1;
              hold_cnt   <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end else begin
            hold_cnt <= '0;
          end
        end
        GRANT1: begin
          if (!m1_req) begin
            hold_cnt <= '0;
            if (m0_req) begin
              state      <= GRANT0;
              last_owner <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (m0_req) begin
            if (hold_cnt == HOLD_LAST) begin
              state      <= GRANT0;
              last_owner <= 1'b0;
              hold_cnt   <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end else begin
            hold_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    m0_grant  = (state == GRANT0);
    m1_grant  = (state == GRANT1);
    s_address = '0;
    s_din     = '0;
    wr_raw    = 1'b0;
    own_req   = 1'b0;
    case (state)
      GRANT0: begin
        s_address = m0_address;
        s_din     = m0_dout;
        wr_raw    = m0_wr & m0_req;
        own_req   = m0_req;
      end
      GRANT1: begin
        s_address = m1_address;
        s_din     = m1_dout;
        wr_raw    = m1_wr & m1_req;
        own_req   = m1_req;
      end
      default: ;
    endcase
    // only slaves 0x00..0x04 exist in the upper address byte
    bus_err = own_req && (s_address[15:8] > 8'h04);
    s_wr    = wr_raw & ~bus_err;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int MAX_HOLD = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [15:0] m0_address, m1_address;
  logic [31:0] m0_dout, m1_dout;
  logic        m0_grant, m1_grant, s_wr, bus_err;
  logic [15:0] s_address;
  logic [31:0] s_din;

  int total = 0;
  int bad   = 0;

  bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant),
    .s_wr(s_wr), .s_address(s_address), .s_din(s_din), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    m0_req = 0; m0_wr = 0; m0_address = '0; m0_dout = '0;
    m1_req = 0; m1_wr = 0; m1_address = '0; m1_dout = '0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    m0_req = 1; m1_req = 1; m0_wr = 1; m1_wr = 1;
    m0_address = 16'h0123; m1_address = 16'h0321;
    m0_dout = 32'h11111111; m1_dout = 32'h22222222;
    tick(); tick();
    total++;
    if ({m0_grant, m1_grant} !== 2'b00) begin
      bad++; $display("FAIL reset_grants got=%b exp=00", {m0_grant, m1_grant});
    end
    total++;
    if ({s_wr, bus_err, s_address, s_din} !== '0) begin
      bad++; $display("FAIL reset_bus got wr=%b err=%b addr=%h din=%h exp=all zero",
                      s_wr, bus_err, s_address, s_din);
    end
    reset = 0;
  endtask

  task automatic test_tie_handover();
    do_reset();
    m0_req = 1; m1_req = 1;
    tick();
    total++;
    if ({m0_grant, m1_grant} !== 2'b10) begin
      bad++; $display("FAIL tie_first got=%b exp=10", {m0_grant, m1_grant});
    end
    m0_req = 0;
    tick();
    total++;
    if ({m0_grant, m1_grant} !== 2'b01) begin
      bad++; $display("FAIL handover got=%b exp=01", {m0_grant, m1_grant});
    end
  endtask

  task automatic test_m1_write();
    do_reset();
    m1_req = 1; m1_wr = 1; m1_address = 16'h0210; m1_dout = 32'hDEADBEEF;
    tick();
    total++;
    if ({m1_grant, s_address, s_din, s_wr} !== {1'b1, 16'h0210, 32'hDEADBEEF, 1'b1}) begin
      bad++; $display("FAIL m1_write got g=%b addr=%h din=%h wr=%b exp g=1 addr=0210 din=deadbeef wr=1",
                      m1_grant, s_address, s_din, s_wr);
    end
  endtask

  task automatic test_hold_preempt();
    int cnt;
    int guard;
    do_reset();
    m0_req = 1;
    tick();
    m1_req = 1;
    cnt = 0; guard = 0;
    while (m0_grant && guard < 40) begin
      cnt++; guard++;
      tick();
    end
    total++;
    if (cnt !== MAX_HOLD) begin
      bad++; $display("FAIL hold_cycles got=%0d exp=%0d", cnt, MAX_HOLD);
    end
    total++;
    if ({m0_grant, m1_grant} !== 2'b01) begin
      bad++; $display("FAIL preempt_grant got=%b exp=01", {m0_grant, m1_grant});
    end
  endtask

  task automatic test_bus_err();
    logic [15:0] addrs [4] = '{16'h0500, 16'h0400, 16'h04FF, 16'hFF00};
    logic        errs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    m0_req = 1; m0_wr = 1; m0_dout = 32'hA5A5A5A5;
    m0_address = addrs[0];
    tick();
    for (int i = 0; i < 4; i++) begin
      m0_address = addrs[i];
      #1;
      total++;
      if ({bus_err, s_wr} !== {errs[i], ~errs[i]}) begin
        bad++; $display("FAIL bus_err addr=%h got err=%b wr=%b exp err=%b wr=%b",
                        addrs[i], bus_err, s_wr, errs[i], ~errs[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_req = 1;
    tick();
    m0_req = 1;
    tick();
    total++;
    if ({m0_grant, m1_grant} !== 2'b01) begin
      bad++; $display("FAIL mid_pre got=%b exp=01", {m0_grant, m1_grant});
    end
    reset = 1;
    tick();
    total++;
    if ({m0_grant, m1_grant} !== 2'b00) begin
      bad++; $display("FAIL mid_reset got=%b exp=00", {m0_grant, m1_grant});
    end
    reset = 0;
    tick();
    total++;
    if ({m0_grant, m1_grant} !== 2'b10) begin
      bad++; $display("FAIL mid_rearb got=%b exp=10", {m0_grant, m1_grant});
    end
  endtask

  task automatic test_release_idle();
    for (int m = 0; m < 2; m++) begin
      do_reset();
      m0_address = 16'h0123; m0_dout = 32'h01234567; m0_wr = 1;
      m1_address = 16'h0345; m1_dout = 32'h89ABCDEF; m1_wr = 1;
      if (m == 0) m0_req = 1; else m1_req = 1;
      tick();
      m0_req = 0; m1_req = 0;
      tick();
      total++;
      if ({m0_grant, m1_grant, s_wr, s_address, s_din} !== '0) begin
        bad++; $display("FAIL release_idle m=%0d got g=%b%b wr=%b addr=%h din=%h exp all zero",
                        m, m0_grant, m1_grant, s_wr, s_address, s_din);
      end
    end
  endtask

  // Reference model: who owns the bus, who owned it last, and how many
  // cycles in a row the owner has kept it while the other master waited.
  task automatic test_random();
    int owner, last, waited;
    logic eg0, eg1, ewr, eerr, oreq, owr;
    logic [15:0] ea;
    logic [31:0] ed;
    logic r0, r1, rs;
    do_reset();
    owner = -1; last = 1; waited = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) m0_req = ~m0_req;
      if ($urandom_range(0, 7) == 0) m1_req = ~m1_req;
      m0_wr = 1'($urandom); m1_wr = 1'($urandom);
      m0_address = {8'($urandom_range(0, 6)), 8'($urandom)};
      m1_address = {8'($urandom_range(0, 6)), 8'($urandom)};
      m0_dout = $urandom; m1_dout = $urandom;
      reset = ($urandom_range(0, 199) == 0);
      #1;
      eg0 = (owner == 0); eg1 = (owner == 1);
      ea = '0; ed = '0; oreq = 0; owr = 0;
      if (owner == 0) begin ea = m0_address; ed = m0_dout; oreq = m0_req; owr = m0_wr; end
      if (owner == 1) begin ea = m1_address; ed = m1_dout; oreq = m1_req; owr = m1_wr; end
      eerr = oreq && (int'(ea >> 8) > 4);
      ewr  = oreq && owr && !eerr;
      total++;
      if ({m0_grant, m1_grant} !== {eg0, eg1}) begin
        bad++; $display("FAIL rnd_grant c=%0d got=%b%b exp=%b%b", c, m0_grant, m1_grant, eg0, eg1);
      end
      total++;
      if (s_address !== ea) begin
        bad++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, s_address, ea);
      end
      total++;
      if (s_din !== ed) begin
        bad++; $display("FAIL rnd_din c=%0d got=%h exp=%h", c, s_din, ed);
      end
      total++;
      if ({s_wr, bus_err} !== {ewr, eerr}) begin
        bad++; $display("FAIL rnd_wr_err c=%0d got wr=%b err=%b exp wr=%b err=%b",
                        c, s_wr, bus_err, ewr, eerr);
      end
      r0 = m0_req; r1 = m1_req; rs = reset;
      tick();
      if (rs) begin
        owner = -1; last = 1; waited = 0;
      end else if (owner < 0) begin
        if (r0 && r1) owner = 1 - last;
        else if (r0) owner = 0;
        else if (r1) owner = 1;
        if (owner >= 0) last = owner;
      end else begin
        oreq = (owner == 0) ? r0 : r1;
        owr  = (owner == 0) ? r1 : r0;
        if (!oreq) begin
          waited = 0;
          owner = owr ? 1 - owner : -1;
          if (owner >= 0) last = owner;
        end else if (owr) begin
          waited = waited + 1;
          if (waited == MAX_HOLD) begin
            owner = 1 - owner; last = owner; waited = 0;
          end
        end else begin
          waited = 0;
        end
      end
    end
    reset = 0;
  endtask

  initial begin
    quiet_inputs();
    reset = 1;
    test_reset();
    test_tie_handover();
    test_m1_write();
    test_hold_preempt();
    test_bus_err();
    test_reset_mid();
    test_release_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
